spatz_strbreq_merge_nport: RTL

SPATZ_STRBREQ_MERGE_NPORT -- requirements
Module: spatz_strbreq_merge_nport

---
 rtl/spatz_strbreq_pkg.sv | 52 +++++
 rtl/spatz_strbreq_merge_lut.sv | 65 ++++++
 rtl/spatz_strbreq_merge_nport.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spatz_strbreq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spatz_strbreq_pkg
// Brief    : Shared constants, the port-count legality check and the default
//            request/response types for the strobe-request merge unit.
// Revision : 1.0 - initial release
// ============================================================================
package spatz_strbreq_pkg;

  // Bits per strobe lane.
  localparam int unsigned ByteWidth = 8;

  // Merge fabric supports power-of-two port counts from 2 to 8.
  function automatic logic num_ports_legal(input int unsigned n);
    return (n == 2) || (n == 4) || (n == 8);
  endfunction

  // Default types used when the instantiating design supplies none.
  typedef logic [3:0] default_req_id_t;

  typedef struct packed {
    default_req_id_t req_id;
    logic [3:0]      tag;
  } default_user_t;

  typedef struct packed {
    logic [31:0]   addr;
    logic          write;
    logic [31:0]   data;
    logic [3:0]    strb;
    default_user_t user;
  } default_req_chan_t;

  typedef struct packed {
    logic              q_valid;
    default_req_chan_t q;
  } default_mem_req_t;

  typedef struct packed {
    logic [31:0]   data;
    logic          write;
    default_user_t user;
  } default_rsp_chan_t;

  typedef struct packed {
    logic              q_ready;
    logic              p_valid;
    default_rsp_chan_t p;
  } default_mem_rsp_t;

endpackage
`default_nettype wire

// File: rtl/spatz_strbreq_merge_lut.sv
`default_nettype none
// ============================================================================
// Module   : spatz_strbreq_merge_lut
// Brief    : Per-leader-port table indexed by req_id. Each entry remembers
//            which ports were folded into a merged write and their users, so
//            the single response can be fanned back out.
// Revision : 1.0 - initial release
// ============================================================================
module spatz_strbreq_merge_lut #(
  parameter int unsigned NumPorts          = 4,
  parameter int unsigned NumOutstandingMem = 16,
  parameter type         req_id_t          = logic [3:0],
  parameter type         tcdm_user_t       = logic [7:0]
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      set_i,
  input  req_id_t                   set_idx_i,
  input  logic       [NumPorts-1:0] set_mask_i,
  input  tcdm_user_t [NumPorts-1:0] set_user_i,
  input  logic                      clr_i,
  input  req_id_t                   clr_idx_i,
  input  req_id_t                   chk_idx_i,
  output logic                      chk_valid_o,
  input  req_id_t                   rsp_idx_i,
  output logic                      rsp_valid_o,
  output logic       [NumPorts-1:0] rsp_mask_o,
  output tcdm_user_t [NumPorts-1:0] rsp_user_o
);

  // Entry layout depends on the user type and port count, so it lives here.
  typedef struct packed {
    logic                      valid;
    logic       [NumPorts-1:0] mask;
    tcdm_user_t [NumPorts-1:0] user;
  } lut_entry_t;

  lut_entry_t lut_q [NumOutstandingMem];

  // Entry update: clear first, then set, so a same-entry set wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < int'(NumOutstandingMem); e++) begin
        lut_q[e] <= '0;
      end
    end else begin
      if (clr_i) begin
        lut_q[clr_idx_i].valid <= 1'b0;
      end
      if (set_i) begin
        lut_q[set_idx_i] <= '{valid: 1'b1, mask: set_mask_i, user: set_user_i};
      end
    end
  end

  // Two combinational read ports: request-side busy check, response-side lookup.
  always_comb begin
    chk_valid_o = lut_q[chk_idx_i].valid;
    rsp_valid_o = lut_q[rsp_idx_i].valid;
    rsp_mask_o  = lut_q[rsp_idx_i].mask;
    rsp_user_o  = lut_q[rsp_idx_i].user;
  end

endmodule
`default_nettype wire

// File: rtl/spatz_strbreq_merge_nport.sv
`default_nettype none
// ============================================================================
// Module   : spatz_strbreq_merge_nport
// Brief    : Folds same-address writes issued in one cycle on several ports
//            into one strobe-merged request on the lowest port, and fans the
//            single write response back out to every folded port.
// Revision : 1.0 - initial release
// ============================================================================
module spatz_strbreq_merge_nport
  import spatz_strbreq_pkg::*;
#(
  parameter int unsigned NumPorts          = 4,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned NumOutstandingMem = 16,
  parameter type         mem_req_t         = default_mem_req_t,
  parameter type         mem_rsp_t         = default_mem_rsp_t,
  parameter type         req_id_t          = default_req_id_t,
  parameter type         tcdm_user_t       = default_user_t
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic                                                merge_en_i,
  input  mem_req_t                                            unmerge_req_i [NumPorts],
  input  logic [NumPorts-1:0]                                 unmerge_pready_i,
  input  mem_rsp_t                                            merge_rsp_i [NumPorts],
  output mem_req_t                                            merge_req_o [NumPorts],
  output logic [NumPorts-1:0]                                 merge_pready_o,
  output mem_rsp_t                                            unmerge_rsp_o [NumPorts],
  output logic [$clog2(NumPorts*NumOutstandingMem+1)-1:0]     lut_occupancy_o
);

  localparam int unsigned NumBytes = DataWidth / ByteWidth;
  localparam int unsigned IdxW     = $clog2(NumPorts);
  localparam int unsigned OccWidth = $clog2(NumPorts*NumOutstandingMem+1);
  localparam logic [OccWidth:0] OccMax = (OccWidth+1)'(NumPorts*NumOutstandingMem);

  if (!num_ports_legal(NumPorts)) begin : g_bad_num_ports
    $error("spatz_strbreq_merge_nport: NumPorts must be a power of two in 2..8");
  end

  // Request-side grouping.
  logic [NumPorts-1:0] is_wr;
  logic [NumPorts-1:0] is_follower;
  logic [IdxW-1:0]     lead_idx [NumPorts];
  logic [NumPorts-1:0] fmask    [NumPorts];

  // LUT interface.
  logic [NumPorts-1:0]                  lut_busy;
  logic [NumPorts-1:0]                  lut_set;
  logic [NumPorts-1:0]                  lut_clr;
  logic [NumPorts-1:0]                  rsp_hit;
  logic [NumPorts-1:0]                  rsp_mask [NumPorts];
  tcdm_user_t [NumPorts-1:0]            rsp_user [NumPorts];
  tcdm_user_t [NumPorts-1:0]            req_users;
  req_id_t                              req_idx  [NumPorts];
  req_id_t                              rsp_idx  [NumPorts];

  // Response-side arbitration.
  logic [NumPorts-1:0] rsp_merged;
  logic [NumPorts-1:0] fanout;
  logic [NumPorts-1:0] claimed;
  logic [NumPorts-1:0] group;

  // Occupancy bookkeeping.
  logic [OccWidth-1:0] occupancy_q;
  logic [OccWidth-1:0] occupancy_d;
  logic [OccWidth:0]   n_set;
  logic [OccWidth:0]   n_clr;
  logic [OccWidth:0]   occ_sum;
  logic [OccWidth:0]   occ_net;

  // Gather the per-port req_ids and users the LUTs index and store.
  always_comb begin
    req_users = '0;
    for (int p = 0; p < NumPorts; p++) begin
      req_idx[p]   = req_id_t'(unmerge_req_i[p].q.user.req_id);
      rsp_idx[p]   = req_id_t'(merge_rsp_i[p].p.user.req_id);
      req_users[p] = tcdm_user_t'(unmerge_req_i[p].q.user);
    end
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_lut
    spatz_strbreq_merge_lut #(
      .NumPorts          (NumPorts),
      .NumOutstandingMem (NumOutstandingMem),
      .req_id_t          (req_id_t),
      .tcdm_user_t       (tcdm_user_t)
    ) i_lut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .set_i       (lut_set[p]),
      .set_idx_i   (req_idx[p]),
      .set_mask_i  (fmask[p]),
      .set_user_i  (req_users),
      .clr_i       (lut_clr[p]),
      .clr_idx_i   (rsp_idx[p]),
      .chk_idx_i   (req_idx[p]),
      .chk_valid_o (lut_busy[p]),
      .rsp_idx_i   (rsp_idx[p]),
      .rsp_valid_o (rsp_hit[p]),
      .rsp_mask_o  (rsp_mask[p]),
      .rsp_user_o  (rsp_user[p])
    );
  end

  // Assign each write to the lowest eligible same-address leader; scanning
  // j downwards lets the lowest candidate overwrite higher ones.
  always_comb begin
    is_follower = '0;
    for (int p = 0; p < NumPorts; p++) begin
      is_wr[p]    = unmerge_req_i[p].q_valid & unmerge_req_i[p].q.write;
      lead_idx[p] = '0;
      fmask[p]    = '0;
    end
    for (int i = 1; i < NumPorts; i++) begin
      for (int j = i - 1; j >= 0; j--) begin
        if (merge_en_i && is_wr[i] && is_wr[j] && !is_follower[j] && !lut_busy[j] &&
            (unmerge_req_i[i].q.addr == unmerge_req_i[j].q.addr)) begin
          is_follower[i] = 1'b1;
          lead_idx[i]    = IdxW'(j);
        end
      end
    end
    for (int i = 0; i < NumPorts; i++) begin
      if (is_follower[i]) begin
        fmask[lead_idx[i]][i] = 1'b1;
      end
    end
  end

  // Build merged leader requests and squash followers. Members are scanned
  // in ascending order, so the highest strobing member owns each byte.
  always_comb begin
    lut_set = '0;
    for (int p = 0; p < NumPorts; p++) begin
      merge_req_o[p] = unmerge_req_i[p];
      if (is_follower[p]) begin
        merge_req_o[p].q_valid = 1'b0;
      end
    end
    for (int j = 0; j < NumPorts; j++) begin
      if (|fmask[j]) begin
        for (int m = j + 1; m < NumPorts; m++) begin
          if (fmask[j][m]) begin
            merge_req_o[j].q.strb = merge_req_o[j].q.strb | unmerge_req_i[m].q.strb;
            for (int b = 0; b < int'(NumBytes); b++) begin
              if (unmerge_req_i[m].q.strb[b]) begin
                merge_req_o[j].q.data[b*ByteWidth +: ByteWidth] =
                  unmerge_req_i[m].q.data[b*ByteWidth +: ByteWidth];
              end
            end
          end
        end
        lut_set[j] = unmerge_req_i[j].q_valid & merge_rsp_i[j].q_ready;
      end
    end
  end

  // Response routing: arbitrate merged responses, stall incomplete groups,
  // then overlay the fan-out copies last so they are never overwritten.
  always_comb begin
    claimed    = '0;
    group      = '0;
    rsp_merged = '0;
    fanout     = '0;
    merge_pready_o = unmerge_pready_i;
    for (int p = 0; p < NumPorts; p++) begin
      unmerge_rsp_o[p] = merge_rsp_i[p];
    end
    // Followers see the leader's request acceptance.
    for (int i = 0; i < NumPorts; i++) begin
      if (is_follower[i]) begin
        unmerge_rsp_o[i].q_ready = merge_rsp_i[lead_idx[i]].q_ready;
      end
    end
    // Lowest-index leader wins any port shared between two groups.
    for (int j = 0; j < NumPorts; j++) begin
      group    = rsp_mask[j];
      group[j] = 1'b1;
      rsp_merged[j] = merge_rsp_i[j].p_valid & merge_rsp_i[j].p.write & rsp_hit[j];
      if (rsp_merged[j] && ((group & claimed) == '0)) begin
        claimed   = claimed | group;
        fanout[j] = &(unmerge_pready_i | ~group);
      end
    end
    lut_clr = fanout;
    // A merged response only completes together with its whole group.
    for (int j = 0; j < NumPorts; j++) begin
      if (rsp_merged[j]) begin
        merge_pready_o[j]         = fanout[j];
        unmerge_rsp_o[j].p_valid  = fanout[j];
      end
    end
    // Replicate the response to each follower with its stored user.
    for (int j = 0; j < NumPorts; j++) begin
      if (fanout[j]) begin
        for (int f = 0; f < NumPorts; f++) begin
          if (rsp_mask[j][f]) begin
            merge_pready_o[f]          = 1'b0;
            unmerge_rsp_o[f].p_valid   = 1'b1;
            unmerge_rsp_o[f].p         = merge_rsp_i[j].p;
            unmerge_rsp_o[f].p.user    = rsp_user[j][f];
          end
        end
      end
    end
  end

  // Net the cycle's sets and clears, saturating at both ends.
  always_comb begin
    n_set = '0;
    n_clr = '0;
    for (int p = 0; p < NumPorts; p++) begin
      n_set = n_set + {{OccWidth{1'b0}}, lut_set[p]};
      n_clr = n_clr + {{OccWidth{1'b0}}, lut_clr[p]};
    end
    occ_sum = {1'b0, occupancy_q} + n_set;
    occ_net = occ_sum - n_clr;
    if (occ_sum < n_clr) begin
      occupancy_d = '0;
    end else if (occ_net > OccMax) begin
      occupancy_d = OccMax[OccWidth-1:0];
    end else begin
      occupancy_d = occ_net[OccWidth-1:0];
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign lut_occupancy_o = occupancy_q;

endmodule
`default_nettype wire
